dsp_chain_sop_collector: RTL and testbench
==========================================

# dsp_chain_sop_collector

Receive-side companion to the integer sum-of-products DSP cascade. Accepts the 37-bit signed `chainout`/`resulta` stream leaving the last chain stage, accumulates beats into per-packet dot-product totals in a wide accumulator with saturation, and presents finished totals through a 2-entry output queue with a valid/ready handshake. Sits between the DSP chain and downstream consumers so that results can be drained under backpressure.

## Interface
- `IN_W`, 37: input beat width; matches the chain result width.
- `ACC_W`, 48: accumulator and output width; must satisfy `ACC_W > IN_W`.
- `CNT_W`, 16: beat-counter width.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `in_valid`  in  1  `in_data` carries a beat.
- `in_data`  in  IN_W  signed two's-complement chain result.
- `in_last`  in  1  the beat closes the current packet.
- `in_ready`  out  1  collector can accept a beat.
- `out_valid`  out  1  queue head holds a finished total.
- `out_ready`  in  1  consumer takes the head.
- `out_data`  out  ACC_W  signed packet total, saturated.
- `out_count`  out  CNT_W  beats in the packet, saturating at all-ones.
- `out_sat`  out  1  saturation occurred somewhere in this packet.

## Operation
- A beat is accepted when `in_valid && in_ready`. `in_ready` = queue not full (occupancy < 2). It is registered-derived and has no combinational path from `out_ready`.
- FSM states:
  - IDLE: accumulator = 0, count = 0. An accepted non-last beat moves to ACCUM. An accepted last beat pushes a single-beat result and stays in IDLE.
  - ACCUM: each accepted beat adds to the accumulator. An accepted last beat pushes the result, clears the accumulator, count and sat flag, and returns to IDLE.
- Arithmetic:
  - `in_data` is sign-extended to ACC_W and added in ACC_W+1 bits.
  - If the sum exceeds the signed ACC_W range, it clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and the packet sat flag is set (sticky until push).
  - Later beats keep adding to the clamped value.
- Pushed entry = {total including the last beat, count including the last beat, sat flag including the last beat}.
- Count increments per accepted beat and holds at 2^CNT_W-1.
- Queue is a 2-entry FIFO with head at index 0.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- When no beat is accepted (`in_valid`=0 or `in_ready`=0), accumulator, count and FSM state hold.
- `in_last` is ignored when `in_valid`=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `out_sat`=0, FSM=IDLE, occupancy=0.
- Latency: a last beat accepted at edge N gives `out_valid`=1 with its entry at the head after edge N, when the queue was empty.
- `out_data`, `out_count` and `out_sat` are registered outputs taken from the head entry. They hold stable while `out_valid`=1 and `out_ready`=0.
- Full queue:
  - `in_ready`=0 from the cycle after the second push until the cycle after a pop.
  - A popping cycle at full does not accept a beat; the freed slot is visible one cycle later.
- Empty queue with `out_ready`=1: no pop occurs and `out_valid` stays 0.
- Asynchronous reset mid-packet or mid-drain discards the partial accumulator and all queued entries. Outputs return to their reset values without waiting for `clk`. The first accepted beat after deassertion starts a new packet.
- Throughput: one beat per cycle while the queue is not full.

## Test plan
- Three-beat packet 100, 200, -50 (last on the third beat), `out_ready`=1: one result one cycle later with `out_data`=250, `out_count`=3, `out_sat`=0; `out_valid` high for exactly 1 cycle.
- Single-beat packet -2^36 with `in_last`=1 in IDLE: `out_data`=-68719476736, `out_count`=1.
- Overflow:
  - Stimulus: 2^12 beats of +(2^36-1), the last one flagged.
  - Required: `out_data`=2^47-1 and `out_sat`=1.
  - The following packet, beat 5 (last), gives `out_data`=5 and `out_sat`=0.
- Backpressure:
  - Stimulus: `out_ready`=0, three single-beat packets 1, 2, 3 offered back-to-back.
  - Required: `in_ready` drops after the second push and beat 3 stalls.
  - Required: with `out_ready` raised, outputs are 1, 2, 3 in order, and beat 3 is accepted one cycle after the first pop.
- Reset mid-packet:
  - Stimulus: two non-last beats of 7, pulse `reset`=0, then the single packet 9 (last).
  - Required: `out_data`=9, `out_count`=1, and no stale entry is emitted.
- Simultaneous push and pop:
  - Stimulus: occupancy 1, `out_ready`=1, last beat accepted in the same cycle.
  - Required: occupancy stays 1, the new total appears at the head the next cycle, and `out_valid` remains 1.

Source files
------------

// File: rtl/dsp_chain_sop_collector.sv
// Collects signed chain-result beats into saturating per-packet totals and
// drains them through a 2-entry valid/ready output queue.
//
// state | meaning
// IDLE  | no packet in progress; accumulator and count are zero
// ACCUM | packet open; accumulator/count/sat hold the partial result
`timescale 1ns/1ps
module dsp_chain_sop_collector #(
  parameter int IN_W  = 37,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;

  logic [1:0]       occ;
  logic [ACC_W-1:0] q0_data, q1_data;
  logic [CNT_W-1:0] q0_cnt, q1_cnt;
  logic             q0_sat, q1_sat;

  logic             accept, push, pop;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] sum_clamped;
  logic [CNT_W-1:0] cnt_inc;

  // Both flags come straight from the occupancy register, so in_ready has
  // no combinational path from out_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_last;
  assign pop       = out_valid && out_ready;

  assign sum = {{(ACC_W-IN_W+1){in_data[IN_W-1]}}, in_data} + {acc[ACC_W-1], acc};
  assign ovf = (sum[ACC_W] != sum[ACC_W-1]);
  assign sum_clamped = !ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    case (state)
      IDLE: begin
        if (accept && !in_last) begin
          acc_nxt   = sum_clamped;
          cnt_nxt   = cnt_inc;
          sat_nxt   = sat | ovf;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            acc_nxt = sum_clamped;
            cnt_nxt = cnt_inc;
            sat_nxt = sat | ovf;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Push with pop is only possible at occupancy 1, so the new entry lands at the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ     <= 2'd0;
      q0_data <= '0;
      q0_cnt  <= '0;
      q0_sat  <= 1'b0;
      q1_data <= '0;
      q1_cnt  <= '0;
      q1_sat  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            q0_data <= sum_clamped;
            q0_cnt  <= cnt_inc;
            q0_sat  <= sat | ovf;
          end else begin
            q1_data <= sum_clamped;
            q1_cnt  <= cnt_inc;
            q1_sat  <= sat | ovf;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          q0_data <= q1_data;
          q0_cnt  <= q1_cnt;
          q0_sat  <= q1_sat;
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          q0_data <= sum_clamped;
          q0_cnt  <= cnt_inc;
          q0_sat  <= sat | ovf;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = q0_data;
  assign out_count = q0_cnt;
  assign out_sat   = q0_sat;

endmodule

// File: tb/tb_dsp_chain_sop_collector.sv
// Scoreboard bench for dsp_chain_sop_collector: directed cases plus random
// packets under random backpressure, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_dsp_chain_sop_collector;
  localparam int IN_W  = 37;
  localparam int ACC_W = 48;
  localparam int CNT_W = 16;
  localparam longint ACC_MAX = (64'sd1 <<< 47) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< 47);
  localparam longint IN_MAX  = (64'sd1 <<< 36) - 64'sd1;
  localparam longint IN_MIN  = -(64'sd1 <<< 36);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, out_sat;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept_cyc = 0;
  int pop_cyc = 0;
  bit rnd_bp = 1'b0;

  typedef struct { longint d; int c; bit s; } exp_t;
  exp_t sb[$];
  longint m_acc = 0;
  int m_cnt = 0;
  bit m_sat = 1'b0;

  dsp_chain_sop_collector #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 1'b0;
  endfunction

  function automatic void model_beat(longint d, bit last);
    exp_t e;
    m_acc = m_acc + d;
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
    else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      e.d = m_acc; e.c = m_cnt; e.s = m_sat;
      sb.push_back(e);
      model_clear();
    end
  endfunction

  task automatic send(longint d, bit last);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data = d[IN_W-1:0];
    in_last = last;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled expected=accepted");
    end else begin
      last_accept_cyc = cyc;
      model_beat(d, last);
    end
  endtask

  function automatic longint rnd_beat();
    longint t;
    logic signed [IN_W-1:0] r;
    case ($urandom_range(0, 9))
      0: return IN_MAX;
      1: return IN_MIN;
      default: begin
        t = {$urandom(), $urandom()};
        r = t[IN_W-1:0];
        return longint'(r);
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d expected=none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_count", out_count, e.c);
        chk("out_sat", out_sat, e.s);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sat", out_sat, 0);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // three-beat packet
    send(100, 0); send(200, 0); send(-50, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 250);
    chk("t1_count", out_count, 3);
    chk("t1_sat", out_sat, 0);
    @(posedge clk); #1;
    chk("t1_valid_pulse", out_valid, 0);

    // single-beat most negative input
    send(IN_MIN, 1);
    chk("t2_data", out_data, -64'sd68719476736);
    chk("t2_count", out_count, 1);
    @(posedge clk); #1;

    // positive overflow, then a clean packet
    for (int i = 0; i < 4096; i++) send(IN_MAX, i == 4095);
    chk("ovf_data", out_data, ACC_MAX);
    chk("ovf_sat", out_sat, 1);
    chk("ovf_count", out_count, 4096);
    send(5, 1);
    chk("post_ovf_data", out_data, 5);
    chk("post_ovf_sat", out_sat, 0);

    // negative overflow, later beat adds to clamped value
    for (int i = 0; i < 4096; i++) send(IN_MIN, 0);
    send(10, 1);
    chk("neg_ovf_data", out_data, ACC_MIN + 10);
    chk("neg_ovf_sat", out_sat, 1);
    chk("neg_ovf_count", out_count, 4097);
    repeat (2) @(posedge clk); #1;

    // backpressure
    out_ready = 1'b0;
    send(1, 1); send(2, 1);
    chk("bp_in_ready_low", in_ready, 0);
    fork
      send(3, 1);
      begin
        repeat (3) @(posedge clk); #1;
        chk("bp_stall", in_ready, 0);
        chk("bp_hold_data", out_data, 1);
        pop_cyc = cyc + 1;
        out_ready = 1'b1;
      end
    join
    chk("bp_accept_cycle", last_accept_cyc, pop_cyc + 1);
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // async reset mid-packet with a queued entry
    out_ready = 1'b0;
    send(33, 1);
    send(7, 0); send(7, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_data", out_data, 0);
    chk("arst_count", out_count, 0);
    sb.delete();
    model_clear();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(9, 1);
    chk("arst_new_data", out_data, 9);
    chk("arst_new_count", out_count, 1);
    repeat (2) @(posedge clk); #1;
    chk("arst_no_stale", out_valid, 0);

    // simultaneous push and pop at occupancy 1
    out_ready = 1'b0;
    send(11, 1);
    out_ready = 1'b1;
    send(12, 1);
    chk("pp_valid", out_valid, 1);
    chk("pp_data", out_data, 12);
    chk("pp_in_ready", in_ready, 1);
    repeat (2) @(posedge clk); #1;

    // random packets under random backpressure
    rnd_bp = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(rnd_beat(), j == len - 1);
      end
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    chk("final_sb_empty", sb.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
